// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start, DATA_W data bits (LSB first), parity, stop.
// Delivers each word with a one-cycle valid pulse, error flags and a saturating bad-frame count.
module parity_frame_rx #(
   parameter int DATA_W     = 3,
   parameter bit ODD_PARITY = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_en,
   input  logic              rx_in,
   output logic [DATA_W-1:0] data_out,
   output logic              valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy,
   output logic [7:0]        err_cnt
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT_HIGH} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   sh_q, sh_d;
   logic                acc_q, acc_d;
   logic                perr_q, perr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                valid_q, valid_d;
   logic                pe_q, pe_d;
   logic                fe_q, fe_d;
   logic [7:0]          ecnt_q, ecnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         acc_q   <= 1'b0;
         perr_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         pe_q    <= 1'b0;
         fe_q    <= 1'b0;
         ecnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         perr_q  <= perr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         pe_q    <= pe_d;
         fe_q    <= fe_d;
         ecnt_q  <= ecnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      perr_d  = perr_q;
      data_d  = data_q;
      pe_d    = pe_q;
      fe_d    = fe_q;
      ecnt_d  = ecnt_q;
      // valid is a pulse: it drops on the next edge whether or not a strobe arrives
      valid_d = 1'b0;
      if (bit_en) begin
         case (state_q)
            IDLE: begin
               if (!rx_in) begin
                  state_d = DATA;
                  cnt_d   = '0;
                  acc_d   = 1'b0;
               end
            end
            DATA: begin
               for (int i = 0; i < DATA_W; i++)
                  if (cnt_q == CNT_W'(i)) sh_d[i] = rx_in;
               acc_d = acc_q ^ rx_in;
               if (cnt_q == CNT_W'(DATA_W-1)) state_d = PARITY;
               else                           cnt_d   = cnt_q + 1'b1;
            end
            PARITY: begin
               perr_d  = acc_q ^ rx_in ^ ODD_PARITY;
               state_d = STOP;
            end
            STOP: begin
               data_d  = sh_q;
               pe_d    = perr_q;
               fe_d    = ~rx_in;
               valid_d = 1'b1;
               if ((perr_q || !rx_in) && ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
               // a low stop bit must see the line return high before another start is accepted
               state_d = rx_in ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
               if (rx_in) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign data_out   = data_q;
   assign valid      = valid_q;
   assign parity_err = pe_q;
   assign frame_err  = fe_q;
   assign busy       = (state_q != IDLE);
   assign err_cnt    = ecnt_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: directed scenarios plus random frames against a frame-level model.
module tb_parity_frame_rx;
   localparam int DATA_W = 3;

   logic              clk = 1'b0;
   logic              rst, bit_en, rx_in;
   logic [DATA_W-1:0] data_out;
   logic              valid, parity_err, frame_err, busy;
   logic [7:0]        err_cnt;

   int tests = 0;
   int fails = 0;

   // frame-level model of the last delivered result
   logic [DATA_W-1:0] exp_data;
   logic              exp_pe, exp_fe;
   int                exp_cnt;

   parity_frame_rx #(.DATA_W(DATA_W), .ODD_PARITY(1'b0)) dut (
      .clk(clk), .rst(rst), .bit_en(bit_en), .rx_in(rx_in),
      .data_out(data_out), .valid(valid), .parity_err(parity_err),
      .frame_err(frame_err), .busy(busy), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic en, input logic rx);
      bit_en = en;
      rx_in  = rx;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_hold(input string tag);
      chk({tag, "_valid"}, 32'(valid), 32'd0);
      chk({tag, "_data"},  32'(data_out), 32'(exp_data));
      chk({tag, "_pe"},    32'(parity_err), 32'(exp_pe));
      chk({tag, "_fe"},    32'(frame_err), 32'(exp_fe));
      chk({tag, "_cnt"},   32'(err_cnt), 32'(exp_cnt));
   endtask

   // drive one frame; each strobe is preceded by gap-1 non-strobe cycles carrying random line noise
   task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic stop,
                             input int gap, input string tag);
      logic [DATA_W+2:0] bits;
      bits = {stop, p, d, 1'b0};
      for (int i = 0; i < DATA_W + 3; i++) begin
         for (int g = 1; g < gap; g++) begin
            tick(1'b0, 1'($urandom));
            chk_hold({tag, "_gap"});
         end
         tick(1'b1, bits[i]);
         if (i < DATA_W + 2) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk_hold({tag, "_mid"});
         end
      end
      exp_data = d;
      exp_pe   = (^d) ^ p;
      exp_fe   = ~stop;
      if ((exp_pe || exp_fe) && exp_cnt < 255) exp_cnt++;
      chk({tag, "_valid"}, 32'(valid), 32'd1);
      chk({tag, "_data"},  32'(data_out), 32'(exp_data));
      chk({tag, "_pe"},    32'(parity_err), 32'(exp_pe));
      chk({tag, "_fe"},    32'(frame_err), 32'(exp_fe));
      chk({tag, "_cnt"},   32'(err_cnt), 32'(exp_cnt));
      chk({tag, "_busy_end"}, 32'(busy), 32'(!stop));
   endtask

   initial begin
      logic [DATA_W-1:0] rd;
      logic              rp, rs;
      int                rg;

      rst = 1'b1; bit_en = 1'b0; rx_in = 1'b1;
      exp_data = '0; exp_pe = 1'b0; exp_fe = 1'b0; exp_cnt = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_pe", 32'(parity_err), 32'd0);
      chk("rst_fe", 32'(frame_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cnt", 32'(err_cnt), 32'd0);
      rst = 1'b0;
      tick(1'b1, 1'b1);
      chk("idle_busy", 32'(busy), 32'd0);

      // good frame, then parity error, then good frame that clears the flag
      send_frame(3'b101, 1'b0, 1'b1, 1, "good");
      tick(1'b1, 1'b1);
      chk_hold("good_after");
      send_frame(3'b101, 1'b1, 1'b1, 1, "perr");
      send_frame(3'b011, 1'b0, 1'b1, 1, "b2b_good");

      // framing error with the line stuck low afterwards
      send_frame(3'b011, 1'b0, 1'b0, 1, "ferr");
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, 1'b0);
         chk("stuck_busy", 32'(busy), 32'd1);
         chk_hold("stuck");
      end
      tick(1'b1, 1'b1);
      chk("release_busy", 32'(busy), 32'd0);
      chk_hold("release");

      // strobe every 4th cycle
      send_frame(3'b100, 1'b1, 1'b1, 4, "gap4");
      tick(1'b0, 1'b1);
      chk_hold("gap4_after");

      // reset after the second data bit
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b0);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      exp_data = '0; exp_pe = 1'b0; exp_fe = 1'b0; exp_cnt = 0;
      chk("arst_busy", 32'(busy), 32'd0);
      chk_hold("arst");
      @(posedge clk); #1;
      rst = 1'b0;
      tick(1'b1, 1'b1);
      send_frame(3'b111, 1'b1, 1'b1, 1, "post_rst");

      // random frames: random data, parity, stop and strobe spacing
      for (int n = 0; n < 40; n++) begin
         rd = DATA_W'($urandom);
         rp = 1'($urandom);
         rs = ($urandom_range(0, 3) != 0);
         rg = $urandom_range(1, 3);
         send_frame(rd, rp, rs, rg, "rand");
         if (!rs) begin
            tick(1'b1, 1'b1);
            chk("rand_release", 32'(busy), 32'd0);
         end
         if ($urandom_range(0, 1) == 1) begin
            tick(1'b1, 1'b1);
            chk_hold("rand_idle");
         end
      end

      // saturation: 260 parity-error frames back to back
      for (int n = 0; n < 260; n++) begin
         rd = DATA_W'($urandom);
         send_frame(rd, ~(^rd), 1'b1, 1, "sat");
      end
      chk("sat_cnt_final", 32'(err_cnt), 32'd255);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/parity_frame_rx.md
# parity_frame_rx

Serial frame receiver and parity checker. It sits directly downstream of the 3-input parity generator, consuming its data bits plus parity bit `p` after they have been serialised onto a single line. The block reassembles each frame, checks parity and the stop bit, and presents the recovered word with a one-cycle valid pulse and error flags. It also keeps a saturating count of bad frames.

## Interface
- `DATA_W`, default 3: number of data bits per frame (3 matches the a/b/c generator).
- `ODD_PARITY`, default 0: 0 means even parity (p = XOR of data bits); 1 means odd parity (p = ~XOR).
- `clk`, input, 1 bit: single clock; all state updates on the rising edge.
- `rst`, input, 1 bit: reset, asynchronous and active-high.
- `bit_en`, input, 1 bit: bit strobe; `rx_in` is sampled only on edges where `bit_en`=1.
- `rx_in`, input, 1 bit: serial line; idles at 1.
- `data_out`, output, DATA_W bits: last received word; bit 0 is the first data bit on the line.
- `valid`, output, 1 bit: one-cycle pulse when `data_out` and the error flags update.
- `parity_err`, output, 1 bit: parity mismatch in the last frame; held until the next `valid`.
- `frame_err`, output, 1 bit: stop bit sampled as 0 in the last frame; held until the next `valid`.
- `busy`, output, 1 bit: 1 in any state other than IDLE.
- `err_cnt`, output, 8 bits: count of frames with `parity_err` or `frame_err` set; saturates at 255.

## Operation
- Frame format, in line order: start (0), d0..d(DATA_W-1), parity, stop (1).
- Five states: IDLE, DATA, PARITY, STOP, WAIT_HIGH. Transitions occur only on edges with `bit_en`=1. With `bit_en`=0, state and all registers hold.
- IDLE:
  - `rx_in`=0 moves to DATA; clears the bit counter and the parity accumulator.
  - `rx_in`=1 stays in IDLE.
- DATA:
  - Each sampled bit goes to position `cnt` of the shift register, and the accumulator takes acc ^= `rx_in`.
  - After DATA_W bits, move to PARITY.
- PARITY: latch perr = acc ^ `rx_in` ^ ODD_PARITY (nonzero means mismatch), then move to STOP.
- STOP, on the same edge:
  - `data_out` <= shift register, `parity_err` <= perr, `frame_err` <= ~`rx_in`, `valid` <= 1.
  - `err_cnt` <= sat(`err_cnt` + 1) if either error is set.
  - Next state is IDLE if `rx_in`=1, otherwise WAIT_HIGH.
- WAIT_HIGH: stay until `rx_in`=1 is sampled, then go to IDLE. A stuck-low line never starts a new frame.
- Frames with errors still deliver `data_out`; the errors are flagged, not dropped.
- `err_cnt` stays at 255 once reached and clears only on reset.

## Timing
- Reset values:
  - State IDLE.
  - `data_out`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0, `err_cnt`=0.
  - Bit counter, shift register and accumulator all 0.
- `rst` asserted mid-frame aborts the frame immediately: no `valid`, no counter change.
- `valid` goes high in the cycle following the edge that samples the stop bit, and is 0 on the next edge regardless of `bit_en`.
- `busy` goes to 1 in the cycle after the start bit is sampled. It goes to 0 after the stop-bit edge (IDLE) or after the line-high edge (WAIT_HIGH).
- Minimum frame length is DATA_W+3 strobes. Back-to-back frames are supported: a start bit on the strobe directly after the stop bit is accepted.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Settings for all scenarios: DATA_W=3, ODD_PARITY=0, `bit_en` tied high unless noted.
- **Good frame.** Line 0,1,0,1,0,1 (data 3'b101, p=0): `data_out`=3'b101, `valid` for one cycle, both error flags 0, `err_cnt`=0.
- **Parity error.** Same frame with p=1: `data_out`=3'b101, `parity_err`=1, `frame_err`=0, `err_cnt`=1. A following good frame with data 3'b011, p=0 clears `parity_err`.
- **Framing error.** Line 0,1,1,0,0,0 (stop bit = 0): `frame_err`=1, `err_cnt` increments. With `rx_in` held 0 for 5 more strobes, `busy` stays 1 and there is no `valid`. Setting `rx_in`=1 returns the block to IDLE.
- **Strobe gaps.** Frame 0,0,0,1,1,1 with `bit_en` high only every 4th cycle: `data_out`=3'b100, no errors, `valid` exactly once, outputs stable between strobes.
- **Reset mid-frame.** Assert `rst` after the second data bit: all outputs return to reset values asynchronously. The next full good frame (data 3'b111, p=1) decodes correctly.
- **Saturation.** 260 consecutive parity-error frames: `err_cnt` reaches 255 and stays there.
